// File: rtl/sort_pkg.sv
// Shared definitions for the sorter and its result serializer: default sizes,
// the serializer state encoding and an element-extraction helper.
package sort_pkg;

    localparam int SORT_W        = 8;
    localparam int SORT_N        = 4;
    // Widest packed vector elem() can slice; N*W must not exceed this.
    localparam int SORT_MAX_BITS = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Returns element i of a packed vector in the low bits; callers truncate to w.
    function automatic logic [SORT_MAX_BITS-1:0] elem(
        input logic [SORT_MAX_BITS-1:0] vec,
        input int unsigned              i,
        input int unsigned              w = SORT_W
    );
        return vec >> (i * w);
    endfunction

endpackage

// File: rtl/sort_result_serializer_if.sv
// Load/stream bundle between a sorter, the result serializer and a downstream
// consumer. The master modport is the serializer side.
interface sort_result_serializer_if #(
    parameter int N = sort_pkg::SORT_N,
    parameter int W = sort_pkg::SORT_W
) ();
    import sort_pkg::*;

    logic           load;
    logic [N*W-1:0] data_in;
    logic           busy;
    // Stream handshake: an element transfers on every rising clk edge where
    // m_valid and m_ready are both high; while m_valid=1 and m_ready=0 the
    // master holds m_valid, m_data and m_last unchanged, and m_valid never
    // waits on m_ready.
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           done;
    logic           order_err;
    state_t         state;

    modport master (
        input  load, data_in, m_ready,
        output busy, m_valid, m_data, m_last, done, order_err, state
    );

    modport slave (
        output load, data_in, m_ready,
        input  busy, m_valid, m_data, m_last, done, order_err, state
    );

endinterface

// File: rtl/sort_result_serializer_order_checker.sv
// Ascending-order monitor for the serialized stream; only built when
// SORT_RESULT_SERIALIZER_CHECK_EN is defined.
`ifdef SORT_RESULT_SERIALIZER_CHECK_EN
module order_checker
    import sort_pkg::*;
#(
    parameter int W = SORT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         hs,
    input  logic         first,
    input  logic [W-1:0] elem_data,
    output logic         order_err
);

    logic [W-1:0] prev_q;
    logic         err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (clear) begin
                err_q <= 1'b0;
            end else if (hs && !first && (elem_data < prev_q)) begin
                err_q <= 1'b1;
            end
            if (hs) begin
                prev_q <= elem_data;
            end
        end
    end

    assign order_err = err_q;

endmodule
`endif

// File: rtl/sort_result_serializer.sv
// Captures a packed N-element sort result on load and streams it out lowest
// index first. Optional order checking: SORT_RESULT_SERIALIZER_CHECK_EN.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input logic                     clk,
    input logic                     rst_n,
    sort_result_serializer_if.master bus
);

    localparam int              IDXW     = $clog2(N);
    localparam int              NW       = N * W;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d, idx_inc;
    logic [NW-1:0]   cap_q, cap_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    data_q, data_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            hs;
    logic            err;

    function automatic logic [W-1:0] pick(
        input logic [NW-1:0]   vec,
        input logic [IDXW-1:0] i
    );
        return W'(elem(SORT_MAX_BITS'(vec), 32'(i), W));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Next element is preloaded on each handshake so the stream has no bubbles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        idx_inc = idx_q + IDXW'(1);
        hs      = valid_q & bus.m_ready;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    cap_d   = bus.data_in;
                    idx_d   = '0;
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = pick(bus.data_in, '0);
                    last_d  = 1'b0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = pick(cap_q, idx_inc);
                        last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SORT_RESULT_SERIALIZER_CHECK_EN
    order_checker #(.W(W)) u_order_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((state_q == IDLE) && bus.load),
        .hs        (hs),
        .first     (idx_q == '0),
        .elem_data (data_q),
        .order_err (err)
    );
`else
    assign err = 1'b0;
`endif

    assign bus.busy      = (state_q == SEND);
    assign bus.m_valid   = valid_q;
    assign bus.m_data    = data_q;
    assign bus.m_last    = last_q;
    assign bus.done      = done_q;
    assign bus.order_err = err;
    assign bus.state     = state_q;

`ifndef SYNTHESIS
    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.m_ready) |=> (valid_q && $stable(data_q) && $stable(last_q)));
    a_busy_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.busy == valid_q));
`endif

endmodule

// File: tb/tb_sort_result_serializer.sv
// Bench for sort_result_serializer: vector table, hand-written reset and
// back-to-back sequences, and random traffic against a queue-level model.
module tb_sort_result_serializer;
    import sort_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NW = N * W;
`ifdef SORT_RESULT_SERIALIZER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [NW-1:0] vec;
        logic [15:0]   rdy;
        logic [15:0]   reload;
        logic [W-1:0]  exp_e [N];
        bit            exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sort_result_serializer_if #(.N(N), .W(W)) bus ();

    sort_result_serializer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    bit           m_busy, exp_done, exp_err, have_prev;
    logic [W-1:0] prev_e;
    vec_t         tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [NW-1:0] vec, input logic [15:0] rdy,
                                input logic [15:0] reload, input logic [W-1:0] e0,
                                input logic [W-1:0] e1, input logic [W-1:0] e2,
                                input logic [W-1:0] e3, input bit err);
        vec_t t;
        t.vec = vec; t.rdy = rdy; t.reload = reload;
        t.exp_e[0] = e0; t.exp_e[1] = e1; t.exp_e[2] = e2; t.exp_e[3] = e3;
        t.exp_err = err;
        return t;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy = 0; exp_done = 0; exp_err = 0; have_prev = 0; prev_e = '0;
    endtask

    // Called at a negedge: check outputs against the model, drive inputs for the
    // coming edge, advance the model by one clock, and wait for the next negedge.
    task automatic tick(input bit ld, input logic [NW-1:0] vec, input bit rdy);
        logic [W-1:0] e;
        check("busy", bus.busy, m_busy);
        check("m_valid", bus.m_valid, m_busy);
        if (m_busy) check("m_data", bus.m_data, exp_q[0]);
        check("m_last", bus.m_last, (m_busy && exp_q.size() == 1));
        check("done", bus.done, exp_done);
        check("order_err", bus.order_err, exp_err);
        bus.load = ld; bus.data_in = vec; bus.m_ready = rdy;
        if (bus.m_valid && rdy) got_q.push_back(bus.m_data);
        exp_done = 0;
        if (m_busy && rdy) begin
            e = exp_q.pop_front();
            if (CHK && have_prev && e < prev_e) exp_err = 1;
            prev_e = e; have_prev = 1;
            if (exp_q.size() == 0) begin
                m_busy = 0; exp_done = 1;
            end
        end else if (!m_busy && ld) begin
            exp_q.delete();
            for (int i = 0; i < N; i++) exp_q.push_back(vec[i*W +: W]);
            m_busy = 1; exp_err = 0; have_prev = 0;
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input logic [NW-1:0] vec, input logic [15:0] rdy, input logic [15:0] reload);
        int k;
        got_q.delete();
        tick(1'b1, vec, 1'b0);
        k = 1;
        while ((m_busy || exp_done) && k < 60) begin
            tick((k < 16) ? reload[k] : 1'b0, 32'hFFFF_FFFF, (k < 16) ? rdy[k] : 1'b1);
            k++;
        end
        check("stream_timeout", (k >= 60), 0);
    endtask

    task automatic check_got(input string name, input logic [W-1:0] e[N]);
        check({name, "_count"}, got_q.size(), N);
        for (int i = 0; i < N; i++)
            if (i < got_q.size()) check(name, got_q[i], e[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
        check({tag, "_m_last"}, bus.m_last, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_order_err"}, bus.order_err, 0);
    endtask

    initial begin
        logic [W-1:0] seq[N];
        int           k;

        bus.load = 0; bus.data_in = '0; bus.m_ready = 0;
        tbl[0] = mk(32'h7856_3412, 16'hFFFF, 16'h0000, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        tbl[1] = mk(32'h7856_3412, 16'hFFD2, 16'h0000, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        tbl[2] = mk(32'h7856_3412, 16'hFFFF, 16'h0014, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        tbl[3] = mk(32'h1234_5678, 16'hFFFF, 16'h0000, 8'h78, 8'h56, 8'h34, 8'h12, CHK);
        tbl[4] = mk(32'h7856_3412, 16'hFFFF, 16'h0000, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        tbl[5] = mk(32'h0D0C_0B0A, 16'hFEEE, 16'h0000, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);

        #1;
        check_all_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            run_vec(tbl[t].vec, tbl[t].rdy, tbl[t].reload);
            check_got("tbl_elem", tbl[t].exp_e);
            check("tbl_err_end", bus.order_err, tbl[t].exp_err);
            tick(1'b0, '0, 1'b1);
        end

        // Reset mid-stream after elements 12 and 34 have been accepted.
        got_q.delete();
        tick(1'b1, 32'h7856_3412, 1'b0);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        #2 rst_n = 0;
        #1;
        check_all_zero("async_rst");
        check("rst_hs_count", got_q.size(), 2);
        model_reset();
        @(negedge clk);
        check_all_zero("held_rst");
        rst_n = 1;
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        run_vec(32'h0403_0201, 16'hFFFF, 16'h0000);
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
        check_got("post_rst_elem", seq);

        // Load in the cycle done pulses must be accepted.
        got_q.delete();
        tick(1'b1, 32'h7856_3412, 1'b1);
        k = 0;
        while (!exp_done && k < 20) begin
            tick(1'b0, '0, 1'b1);
            k++;
        end
        check("b2b_timeout", (k >= 20), 0);
        tick(1'b1, 32'h0D0C_0B0A, 1'b1);
        k = 0;
        while ((m_busy || exp_done) && k < 20) begin
            tick(1'b0, '0, 1'b1);
            k++;
        end
        check("b2b_count", got_q.size(), 2 * N);
        seq[0] = 8'h0A; seq[1] = 8'h0B; seq[2] = 8'h0C; seq[3] = 8'h0D;
        for (int i = 0; i < N; i++)
            if (N + i < got_q.size()) check("b2b_elem", got_q[N+i], seq[i]);

        // Random traffic: loads at any time, random backpressure.
        got_q.delete();
        for (int c = 0; c < 400; c++)
            tick(($urandom_range(0, 4) == 0), NW'($urandom), ($urandom_range(0, 3) != 0));
        for (int c = 0; c < 12; c++)
            tick(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_result_serializer.md
Name: sort_result_serializer

Overview:
Consumer-side counterpart of the parallel sorter. It captures the sorter's packed N-element result on a single-cycle load strobe (driven by the sorter's done) and streams the elements out one per transfer on a valid/ready interface, lowest index first. It sits between the sorting core and any downstream serial consumer (UART bridge, FIFO, checker).

Parameters:
N, 4, number of elements in the packed vector (N >= 2)
W, 8, element width in bits
IDXW, $clog2(N), index counter width (derived, localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  capture strobe; connect to sorter done
data_in  input  N*W  packed vector; element i = data_in[i*W +: W]
busy  output  1  high while a captured vector is still being streamed
m_valid  output  1  m_data holds a valid element
m_ready  input  1  downstream accepts the element when high with m_valid
m_data  output  W  current element
m_last  output  1  high with m_valid on element N-1
done  output  1  one-cycle pulse after the final element's handshake
order_err  output  1  sticky ordering flag (see Optional Feature; tied 0 otherwise)

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, m_valid=0, m_data=0, m_last=0, done=0, order_err=0, idx=0, state=IDLE, capture register=0.
- FSM states: IDLE, SEND.
- IDLE: on load=1, register data_in into an N*W capture register, set idx=0, and go to SEND.
  - m_valid is asserted the cycle after load. This gives load-to-first-valid latency of 1 cycle.
- SEND: m_valid=1, m_data=cap[idx*W +: W], m_last=(idx==N-1). These are registered outputs, stable while m_ready=0.
  - Handshake occurs when m_valid & m_ready.
  - Handshake with idx<N-1: idx increments and the next element is presented the following cycle. A zero-bubble stream is required, so N handshakes take N consecutive cycles when m_ready is held high.
  - Handshake with idx==N-1: go to IDLE, drop m_valid, pulse done for exactly one cycle (the cycle after the last handshake).
- busy = (state==SEND).
- load during SEND is ignored. The capture register and idx are unchanged, and the vector is dropped with no error.
- load arriving in the same cycle as the final handshake is also ignored; the producer must wait for done.
- m_data and m_valid must not change while m_valid=1 and m_ready=0 (AXI-stream stability rule).
- Asserting rst_n low mid-stream aborts the stream immediately. All outputs return to reset values asynchronously, and no done pulse is produced.
- The idx counter never wraps within a transfer; it is reset to 0 only on load.

Optional Feature:
- Macro: SORT_RESULT_SERIALIZER_CHECK_EN.
- Defined: on each handshake with idx>0, compare the element against the previously sent element, held in a W-bit register.
  - If the current element is less than the previous one (unsigned, i.e. not ascending), set order_err.
  - order_err is sticky until the next accepted load or reset.
- Not defined: no compare logic or previous-element register is built, and order_err is tied to 0.

Decomposition:
- Shared package sort_pkg holds:
  - default element width SORT_W=8 and default count SORT_N=4;
  - the state enum {IDLE, SEND};
  - the function elem(vec, i), which returns vec[i*W +: W].
- No sub-module is required; the block is a single FSM plus datapath.
- Optionally, the order checker can be a sub-module order_checker, built only under the macro.

Test Plan:
1. N=4, W=8, m_ready=1; load with data_in=32'h7856_3412 -> m_data=12,34,56,78 on 4 consecutive cycles starting 1 cycle after load; m_last only with 78; done pulses once the cycle after the 78 handshake; busy low afterwards.
2. Same vector, m_ready toggling 1,0,0,1,0,1,1 -> m_data held stable through the stalls; exactly 4 handshakes, in order; done after the 4th handshake only.
3. Load 32'h7856_3412, then during SEND load 32'hFFFF_FFFF -> output is still 12,34,56,78 and no FF appears; a load after done captures the new vector.
4. Deassert rst_n after the second handshake (element 34 accepted) -> m_valid, busy, m_last, done all 0 asynchronously; no done pulse; a post-reset load of 32'h0403_0201 streams 01,02,03,04.
5. With SORT_RESULT_SERIALIZER_CHECK_EN defined, load 32'h1234_5678 -> stream 78,56,34,12; order_err rises after the 56 handshake and stays high; next load of 32'h7856_3412 clears it and it stays 0. Without the macro, order_err stays 0.
6. Back-to-back: load asserted in the cycle done pulses, with 32'h0D0C_0B0A -> accepted (state is IDLE); stream 0A,0B,0C,0D follows with 1-cycle latency.
